sram_bus_arbiter: RTL and testbench
===================================

// Module: sram_bus_arbiter
// PURPOSE
// Shares one SRAM controller bus port between the CPU instruction-fetch port (I) and the
// load/store port (D). Sits between the pipeline memory stages and sram_controller:
// - arbitrates between the two ports, D first;
// - locks the grant for a whole multi-cycle access;
// - returns per-port stall and read data.
// PARAMETERS
// ADDR_W      20  word-address width (matches controller bus_addr)
// DATA_W      32  data width; byte mask is DATA_W/8 bits
// MAX_STREAK  4   consecutive D grants allowed while I waits (only with SRAM_ARB_FAIRNESS_EN)
// PORTS
// clk            in   1         clock
// rst            in   1         asynchronous reset, active-high
// i_read_op      in   1         I port read request (I never writes)
// i_addr         in   ADDR_W    I port word address
// i_rdata        out  DATA_W    I port read data, valid when i_read_op=1 and i_stall=0
// i_stall        out  1         I port must hold its request this cycle
// d_read_op      in   1         D port read request
// d_write_op     in   1         D port write request; wins over d_read_op if both are set
// d_addr         in   ADDR_W    D port word address
// d_wdata        in   DATA_W    D port write data
// d_byte_mask    in   DATA_W/8  D port byte enables, active-high
// d_rdata        out  DATA_W    D port read data, valid when a D read completes
// d_stall        out  1         D port must hold its request this cycle
// bus_read_op    out  1         to controller read_op
// bus_write_op   out  1         to controller write_op
// bus_addr       out  ADDR_W    to controller bus_addr
// bus_data_write out  DATA_W    to controller bus_data_write
// bus_byte_mask  out  DATA_W/8  to controller byte_mask
// bus_data_read  in   DATA_W    from controller bus_data_read
// bus_stall      in   1         from controller: access not finished this cycle
// BEHAVIOUR
// - Controller contract: an access completes in the cycle where an op is driven and
//   bus_stall=0.
// - FSM states: IDLE, BUSY_D, BUSY_I. Reset is asynchronous to IDLE. Reset also clears
//   the latched request and the streak counter.
// - IDLE:
//   - Winner is D if D has a request, else I if I has a request.
//   - The winner's fields drive bus_* combinationally in the same cycle (0-cycle added latency).
//   - With no request: bus_read_op=bus_write_op=0; bus_addr, bus_data_write and
//     bus_byte_mask=0.
//   - Winner with bus_stall=0: the access completes that cycle and the FSM stays in IDLE.
//   - Winner with bus_stall=1: the winner's op, addr, wdata and mask are latched and the
//     FSM moves to BUSY_D or BUSY_I.
// - BUSY_x: bus_* are driven only from the latched copy. When bus_stall=0 the access
//   completes and the FSM returns to IDLE. The next arbitration happens in the following
//   cycle.
// - No back-to-back grant carry-over: after a BUSY completion, the next access always
//   starts from IDLE.
// - Port stall = request asserted AND NOT (this port's access completes this cycle).
//   The loser of an arbitration is stalled. With no request, stall=0.
// - rdata: i_rdata and d_rdata are combinational copies of bus_data_read. A port reads
//   valid data only when its own read completes. Writes return nothing.
// - Request dropped mid-access (pipeline flush): the latched access still runs to
//   completion and its result is discarded. The port sees stall=0 once it stops requesting.
// - Request change while stalled: ignored until the current access completes. After that
//   the new fields are arbitrated fresh.
// - D with both read and write set: treated as a write; bus_read_op stays 0.
// - Reset asserted mid-access: bus_read_op and bus_write_op drop to 0 immediately.
//   The controller shares rst, so no partial access survives.
// CONFIGURATION
// - SRAM_ARB_FAIRNESS_EN defined:
//   - A counter counts consecutive D grants made while I is requesting, saturating at
//     MAX_STREAK.
//   - When the count reaches MAX_STREAK, the next IDLE arbitration grants I even if D
//     is requesting.
//   - Any I grant, or an IDLE cycle with no I request, clears the counter.
// - SRAM_ARB_FAIRNESS_EN undefined: no counter; D has strict priority and I may starve.
// TESTING
// 1. D and I read together, bus_stall=0 always, D addr 0x00010 -> bus_addr=0x00010 in
//    cycle 0 with d_stall=0 and i_stall=1; bus_addr=0x00004 (I) in cycle 1.
// 2. D write 0xDEADBEEF, mask 4'b0011, bus_stall high 2 cycles -> bus fields stay stable
//    3 cycles; d_stall=1,1,0; FSM returns to IDLE.
// 3. I read granted with bus_stall=1, D requests in next cycle -> I access finishes
//    first (lock honoured); D is served in the cycle after.
// 4. D drops its read while in BUSY_D -> bus_read_op stays high until bus_stall=0;
//    d_stall=0 once the request drops.
// 5. rst asserted mid BUSY_I -> bus_read_op=0 asynchronously and both stalls=0.
//    First request after rst release is re-arbitrated from IDLE.
// 6. SRAM_ARB_FAIRNESS_EN, MAX_STREAK=4, D and I requesting continuously, bus_stall=0
//    -> grants D,D,D,D,I,D,...
//    Same test without the macro -> I is never granted.

Source files
------------

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
// Shares one SRAM controller bus port between the instruction-fetch port (I)
// and the load/store port (D). D wins arbitration. A grant that stalls is
// locked: the winner's fields are latched and replayed until the controller
// drops bus_stall.
//
// Optional feature: define SRAM_ARB_FAIRNESS_EN to enable the anti-starvation
// streak counter. Once MAX_STREAK consecutive D grants have been made while I
// was waiting, the next IDLE arbitration goes to I.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   i_read_op       I read request; i_addr is its word address
//   i_rdata         I read data (copy of bus_data_read)
//   i_stall         I must hold its request this cycle
//   d_read_op       D read request
//   d_write_op      D write request (takes precedence over d_read_op)
//   d_addr          D word address
//   d_wdata         D write data
//   d_byte_mask     D byte enables
//   d_rdata         D read data (copy of bus_data_read)
//   d_stall         D must hold its request this cycle
//   bus_*           controller side: read_op, write_op, addr, data_write,
//                   byte_mask out; data_read and stall in
//
// Handshake: a port's access completes in the cycle it owns the bus, an op
// is driven and bus_stall=0. A requesting port sees stall=1 in every other
// cycle, and stall=0 whenever it does not request.
//
// The FSM state is held in the internal signal 'state' (IDLE, BUSY_D,
// BUSY_I) so checkers can bind to it.
module sram_bus_arbiter #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_read_op,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_stall,
  input  logic                d_read_op,
  input  logic                d_write_op,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_byte_mask,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,
  output logic                bus_read_op,
  output logic                bus_write_op,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_data_write,
  output logic [DATA_W/8-1:0] bus_byte_mask,
  input  logic [DATA_W-1:0]   bus_data_read,
  input  logic                bus_stall
);

  localparam int unsigned MASK_W   = DATA_W / 8;
  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t              state;
  logic                lat_read;
  logic                lat_write;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [MASK_W-1:0]   lat_mask;
  logic [STREAK_W-1:0] streak;

  logic                d_req;
  logic                i_req;
  logic                force_i;
  logic                grant_d;
  logic                grant_i;
  logic                arb_read;
  logic                arb_write;
  logic [ADDR_W-1:0]   arb_addr;
  logic [DATA_W-1:0]   arb_wdata;
  logic [MASK_W-1:0]   arb_mask;
  logic                done;
  logic                d_own;
  logic                i_own;

`ifdef SRAM_ARB_FAIRNESS_EN
  localparam bit FAIR_EN = 1'b1;

  // Counts D grants made in IDLE while I is waiting; holds during BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= '0;
    end else if (state == IDLE) begin
      if (!i_req || grant_i) begin
        streak <= '0;
      end else if (grant_d && streak != STREAK_W'(MAX_STREAK)) begin
        streak <= streak + STREAK_W'(1);
      end
    end
  end
`else
  localparam bit FAIR_EN = 1'b0;

  assign streak = '0;
`endif

  assign d_req   = d_read_op | d_write_op;
  assign i_req   = i_read_op;
  assign force_i = FAIR_EN && i_req && (streak == STREAK_W'(MAX_STREAK));
  assign grant_d = d_req & ~force_i;
  assign grant_i = i_req & ~grant_d;

  // Fields of the IDLE-cycle winner. A D write suppresses the read op.
  always_comb begin
    arb_read  = 1'b0;
    arb_write = 1'b0;
    arb_addr  = '0;
    arb_wdata = '0;
    arb_mask  = '0;
    if (grant_d) begin
      arb_read  = d_read_op & ~d_write_op;
      arb_write = d_write_op;
      arb_addr  = d_addr;
      arb_wdata = d_wdata;
      arb_mask  = d_byte_mask;
    end else if (grant_i) begin
      arb_read  = 1'b1;
      arb_addr  = i_addr;
    end
  end

  // Reset forces the bus idle immediately, even if requests are still up.
  always_comb begin
    bus_read_op    = 1'b0;
    bus_write_op   = 1'b0;
    bus_addr       = '0;
    bus_data_write = '0;
    bus_byte_mask  = '0;
    if (!rst) begin
      if (state == IDLE) begin
        bus_read_op    = arb_read;
        bus_write_op   = arb_write;
        bus_addr       = arb_addr;
        bus_data_write = arb_wdata;
        bus_byte_mask  = arb_mask;
      end else begin
        bus_read_op    = lat_read;
        bus_write_op   = lat_write;
        bus_addr       = lat_addr;
        bus_data_write = lat_wdata;
        bus_byte_mask  = lat_mask;
      end
    end
  end

  assign done    = (bus_read_op | bus_write_op) & ~bus_stall;
  assign d_own   = (state == IDLE) ? grant_d : (state == BUSY_D);
  assign i_own   = (state == IDLE) ? grant_i : (state == BUSY_I);
  assign d_stall = ~rst & d_req & ~(d_own & done);
  assign i_stall = ~rst & i_req & ~(i_own & done);
  assign d_rdata = bus_data_read;
  assign i_rdata = bus_data_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_mask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((grant_d || grant_i) && bus_stall) begin
            lat_read  <= arb_read;
            lat_write <= arb_write;
            lat_addr  <= arb_addr;
            lat_wdata <= arb_wdata;
            lat_mask  <= arb_mask;
            state     <= grant_d ? BUSY_D : BUSY_I;
          end
        end
        BUSY_D, BUSY_I: begin
          // Completion always returns to IDLE; the next grant is decided there.
          if (!bus_stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read_op;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_stall;
  logic              d_read_op;
  logic              d_write_op;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_byte_mask;
  logic [DATA_W-1:0] d_rdata;
  logic              d_stall;
  logic              bus_read_op;
  logic              bus_write_op;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_data_write;
  logic [MASK_W-1:0] bus_byte_mask;
  logic [DATA_W-1:0] bus_data_read;
  logic              bus_stall;

  int checks = 0;
  int errors = 0;

  // Clock / reset
  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_read_op(i_read_op), .i_addr(i_addr), .i_rdata(i_rdata), .i_stall(i_stall),
    .d_read_op(d_read_op), .d_write_op(d_write_op), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_byte_mask(d_byte_mask), .d_rdata(d_rdata), .d_stall(d_stall),
    .bus_read_op(bus_read_op), .bus_write_op(bus_write_op), .bus_addr(bus_addr),
    .bus_data_write(bus_data_write), .bus_byte_mask(bus_byte_mask),
    .bus_data_read(bus_data_read), .bus_stall(bus_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver helpers: inputs change 1 time unit after the rising edge,
  // outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_read_op   = 1'b0;
    i_addr      = '0;
    d_read_op   = 1'b0;
    d_write_op  = 1'b0;
    d_addr      = '0;
    d_wdata     = '0;
    d_byte_mask = '0;
    bus_stall   = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_addr [6];
    logic              exp_istall [6];

    rst = 1'b1;
    bus_data_read = '0;
    idle_inputs();
    #3;
    check("reset_rd_op", bus_read_op, 0);
    check("reset_wr_op", bus_write_op, 0);
    check("reset_addr", bus_addr, 0);
    check("reset_d_stall", d_stall, 0);
    check("reset_i_stall", i_stall, 0);
    settle();
    rst = 1'b0;
    next_cycle();

    // No request: bus idle and zeroed
    settle();
    check("idle_rd_op", bus_read_op, 0);
    check("idle_mask", bus_byte_mask, 0);
    next_cycle();

    // 1: D and I read together, no controller stall
    d_read_op = 1'b1; d_addr = 20'h00010;
    i_read_op = 1'b1; i_addr = 20'h00004;
    bus_data_read = 32'hA5A5_0001;
    settle();
    check("t1_c0_addr", bus_addr, 20'h00010);
    check("t1_c0_rd_op", bus_read_op, 1);
    check("t1_c0_d_stall", d_stall, 0);
    check("t1_c0_i_stall", i_stall, 1);
    check("t1_c0_d_rdata", d_rdata, 32'hA5A5_0001);
    next_cycle();
    d_read_op = 1'b0;
    bus_data_read = 32'h1234_5678;
    settle();
    check("t1_c1_addr", bus_addr, 20'h00004);
    check("t1_c1_i_stall", i_stall, 0);
    check("t1_c1_i_rdata", i_rdata, 32'h1234_5678);
    next_cycle();
    idle_inputs();
    next_cycle();

    // 2: D write (read also set) held by two controller stall cycles
    d_write_op = 1'b1; d_read_op = 1'b1;
    d_addr = 20'h00020; d_wdata = 32'hDEADBEEF; d_byte_mask = 4'b0011;
    bus_stall = 1'b1;
    settle();
    check("t2_c0_wr_op", bus_write_op, 1);
    check("t2_c0_rd_op", bus_read_op, 0);
    check("t2_c0_addr", bus_addr, 20'h00020);
    check("t2_c0_wdata", bus_data_write, 32'hDEADBEEF);
    check("t2_c0_mask", bus_byte_mask, 4'b0011);
    check("t2_c0_d_stall", d_stall, 1);
    next_cycle();
    // Changed fields while locked must not reach the bus
    d_addr = 20'h00099; d_wdata = 32'h0; d_byte_mask = 4'b1100;
    settle();
    check("t2_c1_addr", bus_addr, 20'h00020);
    check("t2_c1_wdata", bus_data_write, 32'hDEADBEEF);
    check("t2_c1_mask", bus_byte_mask, 4'b0011);
    check("t2_c1_d_stall", d_stall, 1);
    next_cycle();
    bus_stall = 1'b0;
    settle();
    check("t2_c2_addr", bus_addr, 20'h00020);
    check("t2_c2_wr_op", bus_write_op, 1);
    check("t2_c2_d_stall", d_stall, 0);
    next_cycle();
    idle_inputs();
    settle();
    check("t2_c3_idle_wr", bus_write_op, 0);
    check("t2_c3_idle_addr", bus_addr, 0);
    next_cycle();

    // 3: I locked in BUSY_I, D arrives next cycle and waits
    i_read_op = 1'b1; i_addr = 20'h00008; bus_stall = 1'b1;
    settle();
    check("t3_c0_addr", bus_addr, 20'h00008);
    check("t3_c0_i_stall", i_stall, 1);
    next_cycle();
    d_read_op = 1'b1; d_addr = 20'h00030;
    settle();
    check("t3_c1_addr", bus_addr, 20'h00008);
    check("t3_c1_d_stall", d_stall, 1);
    next_cycle();
    bus_stall = 1'b0;
    settle();
    check("t3_c2_addr", bus_addr, 20'h00008);
    check("t3_c2_i_stall", i_stall, 0);
    check("t3_c2_d_stall", d_stall, 1);
    next_cycle();
    i_read_op = 1'b0;
    settle();
    check("t3_c3_addr", bus_addr, 20'h00030);
    check("t3_c3_d_stall", d_stall, 0);
    next_cycle();
    idle_inputs();
    next_cycle();

    // 4: D drops its read while BUSY_D
    d_read_op = 1'b1; d_addr = 20'h00040; bus_stall = 1'b1;
    settle();
    check("t4_c0_d_stall", d_stall, 1);
    next_cycle();
    d_read_op = 1'b0;
    settle();
    check("t4_c1_rd_op", bus_read_op, 1);
    check("t4_c1_addr", bus_addr, 20'h00040);
    check("t4_c1_d_stall", d_stall, 0);
    next_cycle();
    bus_stall = 1'b0;
    settle();
    check("t4_c2_rd_op", bus_read_op, 1);
    next_cycle();
    settle();
    check("t4_c3_rd_op", bus_read_op, 0);
    next_cycle();

    // 5: reset in the middle of BUSY_I
    i_read_op = 1'b1; i_addr = 20'h00050; bus_stall = 1'b1;
    next_cycle();
    settle();
    check("t5_busy_rd_op", bus_read_op, 1);
    check("t5_busy_addr", bus_addr, 20'h00050);
    next_cycle();
    rst = 1'b1;
    #1;
    check("t5_rst_rd_op", bus_read_op, 0);
    check("t5_rst_i_stall", i_stall, 0);
    check("t5_rst_d_stall", d_stall, 0);
    d_read_op = 1'b1; d_addr = 20'h00060; bus_stall = 1'b0;
    settle();
    rst = 1'b0;
    #1;
    check("t5_rel_addr", bus_addr, 20'h00060);
    check("t5_rel_rd_op", bus_read_op, 1);
    check("t5_rel_d_stall", d_stall, 0);
    check("t5_rel_i_stall", i_stall, 1);
    next_cycle();
    idle_inputs();
    next_cycle();
    next_cycle();

    // 6: D and I both request continuously, no controller stall
`ifdef SRAM_ARB_FAIRNESS_EN
    exp_addr   = '{20'h70, 20'h70, 20'h70, 20'h70, 20'h74, 20'h70};
    exp_istall = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    exp_addr   = '{20'h70, 20'h70, 20'h70, 20'h70, 20'h70, 20'h70};
    exp_istall = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    d_read_op = 1'b1; d_addr = 20'h00070;
    i_read_op = 1'b1; i_addr = 20'h00074;
    for (int k = 0; k < 6; k++) begin
      settle();
      check($sformatf("t6_c%0d_addr", k), bus_addr, exp_addr[k]);
      check($sformatf("t6_c%0d_i_stall", k), i_stall, exp_istall[k]);
      check($sformatf("t6_c%0d_d_stall", k), d_stall, !exp_istall[k]);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
